// File: rtl/bsw_pkg.sv
// Register map, field offsets and size limits shared by the button/switch block
// and its debouncer.
package bsw_pkg;

  localparam int MAX_KEYS = 8;
  localparam int MAX_SW   = 16;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_EVENT  = 2'd1,
    REG_MASK   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_addr_e;

  localparam int SW_LSB      = 0;
  localparam int KEY_LSB     = 16;
  localparam int PRESS_LSB   = 0;
  localparam int RELEASE_LSB = 8;
  localparam int PMASK_LSB   = 0;
  localparam int RMASK_LSB   = 8;

  typedef enum logic {
    DEB_RELEASED = 1'b0,
    DEB_PRESSED  = 1'b1
  } deb_state_e;

endpackage

// File: rtl/bsw_deb_if.sv
// Zero-wait-state register bus between a host and the button/switch block.
interface bsw_deb_if;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        irq;

  modport master (
    output stb, we, addr, data_in,
    input  data_out, ack, irq
  );

  modport slave (
    input  stb, we, addr, data_in,
    output data_out, ack, irq
  );
endinterface

// File: rtl/bsw_debounce.sv
// Single-key debouncer: the stable state flips only after DEB_CYCLES consecutive
// synchronised samples disagree with it.
//   state        | meaning
//   DEB_RELEASED | key accepted as released
//   DEB_PRESSED  | key accepted as pressed
module bsw_debounce
  import bsw_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  deb_state_e       state;
  deb_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             done;

  assign differ = (sample != (state == DEB_PRESSED));
  assign done   = differ && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DEB_RELEASED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DEB_RELEASED: if (done) state_nxt = DEB_PRESSED;
      DEB_PRESSED:  if (done) state_nxt = DEB_RELEASED;
      default:      state_nxt = DEB_RELEASED;
    endcase
  end

  always_comb begin
    stable = (state == DEB_PRESSED);
  end

  // Clearing on the terminal sample keeps the count below DEB_CYCLES, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!differ || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= done && (state == DEB_RELEASED);
      fall <= done && (state == DEB_PRESSED);
    end
  end

endmodule

// File: rtl/bsw_deb.sv
// Button/switch input block: synchronises raw inputs, debounces keys, and exposes
// live status, sticky press/release events and interrupt masks on a 4-register bus.
module bsw_deb
  import bsw_pkg::*;
#(
  parameter int NUM_KEYS   = 4,
  parameter int NUM_SW     = 8,
  parameter int DEB_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  bsw_deb_if.slave            bus,
  input  logic [NUM_KEYS-1:0] keys_n,
  input  logic [NUM_SW-1:0]   sw
);

  logic [NUM_KEYS-1:0] keys_s1;
  logic [NUM_KEYS-1:0] keys_s2;
  logic [NUM_SW-1:0]   sw_s1;
  logic [NUM_SW-1:0]   sw_s2;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] released;
  logic [NUM_KEYS-1:0] pmask;
  logic [NUM_KEYS-1:0] rmask;
  logic [NUM_KEYS-1:0] clr_press;
  logic [NUM_KEYS-1:0] clr_release;
  logic                wr_event;
  logic                wr_mask;
  logic                irq_q;
  logic [31:0]         rdata;
  logic                unused_data;

  // Key synchronisers idle at the released (high) level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_s1 <= '1;
      keys_s2 <= '1;
      sw_s1   <= '0;
      sw_s2   <= '0;
    end else begin
      keys_s1 <= keys_n;
      keys_s2 <= keys_s1;
      sw_s1   <= sw;
      sw_s2   <= sw_s1;
    end
  end

  assign key_level = ~keys_s2;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    bsw_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .sample (key_level[k]),
      .stable (stable[k]),
      .rise   (rise[k]),
      .fall   (fall[k])
    );
  end

  assign wr_event    = bus.stb && bus.we && (bus.addr == REG_EVENT);
  assign wr_mask     = bus.stb && bus.we && (bus.addr == REG_MASK);
  assign clr_press   = wr_event ? bus.data_in[PRESS_LSB +: NUM_KEYS] : '0;
  assign clr_release = wr_event ? bus.data_in[RELEASE_LSB +: NUM_KEYS] : '0;

  // A new edge is OR-ed in after the clear, so it survives a coincident W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed  <= '0;
      released <= '0;
    end else begin
      pressed  <= (pressed & ~clr_press) | rise;
      released <= (released & ~clr_release) | fall;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmask <= '0;
      rmask <= '0;
    end else if (wr_mask) begin
      pmask <= bus.data_in[PMASK_LSB +: NUM_KEYS];
      rmask <= bus.data_in[RMASK_LSB +: NUM_KEYS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (|(pressed & pmask)) || (|(released & rmask));
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_addr_e'(bus.addr))
      REG_STATUS: begin
        rdata[SW_LSB +: MAX_SW]    = MAX_SW'(sw_s2);
        rdata[KEY_LSB +: MAX_KEYS] = MAX_KEYS'(stable);
      end
      REG_EVENT: begin
        rdata[PRESS_LSB +: MAX_KEYS]   = MAX_KEYS'(pressed);
        rdata[RELEASE_LSB +: MAX_KEYS] = MAX_KEYS'(released);
      end
      REG_MASK: begin
        rdata[PMASK_LSB +: MAX_KEYS] = MAX_KEYS'(pmask);
        rdata[RMASK_LSB +: MAX_KEYS] = MAX_KEYS'(rmask);
      end
      REG_RSVD: rdata = '0;
    endcase
  end

  assign bus.data_out = rdata;
  assign bus.ack      = bus.stb;
  assign bus.irq      = irq_q;

  // Only the low event/mask fields of the write data are architected.
  assign unused_data = ^bus.data_in;

endmodule
